// File: rtl/apb_pkg.sv
// Shared types and constants for the APB register-file slave.
package apb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StAccess
  } apb_state_e;

  localparam int unsigned APB_WORD_SHIFT = 2;
  localparam int unsigned ERR_COUNT_W    = 8;

  // State is one cycle behind the bus: StSetup means the previous cycle was a setup phase.
  function automatic apb_state_e apb_next_state(input apb_state_e state,
                                                input logic       psel,
                                                input logic       penable);
    apb_state_e nxt_state;
    nxt_state = StIdle;
    case (state)
      StIdle:   if (psel && !penable) nxt_state = StSetup;
      StSetup:  if (psel && penable)  nxt_state = StAccess;
      StAccess: if (psel && !penable) nxt_state = StSetup;
      default:  nxt_state = StIdle;
    endcase
    return nxt_state;
  endfunction

endpackage

// File: rtl/apb_protocol_checker.sv
// APB phase tracker with violation counting; only built with APB_SLAVE_PROTOCOL_CHECK_EN.
module apb_protocol_checker
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   psel_i,
  input  logic                   penable_i,
  input  logic                   pwrite_i,
  input  logic [ADDR_WIDTH-1:0]  paddr_i,
  output logic                   setup_entry_o,
  output logic                   access_ok_o,
  output logic [ERR_COUNT_W-1:0] err_count_o
);

  apb_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic                   write_q, write_d;
  logic [ERR_COUNT_W-1:0] err_q, err_d;
  logic                   setup_entry, in_access, mismatch, violation;

  always_comb begin
    state_d     = apb_next_state(state_q, psel_i, penable_i);
    setup_entry = psel_i & ~penable_i & (state_q != StSetup);
    in_access   = (state_q == StSetup) & psel_i & penable_i;
    mismatch    = in_access & ((paddr_i != addr_q) | (pwrite_i != write_q));
    violation   = mismatch
                | ((state_q == StIdle)   & psel_i & penable_i)
                | ((state_q == StSetup)  & ~(psel_i & penable_i))
                | ((state_q == StAccess) & psel_i & penable_i);
    addr_d      = setup_entry ? paddr_i  : addr_q;
    write_d     = setup_entry ? pwrite_i : write_q;
    err_d       = err_q;
    if (violation && (err_q != '1)) err_d = err_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      addr_q  <= '0;
      write_q <= 1'b0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      err_q   <= err_d;
    end
  end

  assign setup_entry_o = setup_entry;
  assign access_ok_o   = in_access & ~mismatch;
  assign err_count_o   = err_q;

endmodule

// File: rtl/apb_slave_regfile.sv
// APB completer with a bank of R/W registers exported in parallel.
// Define APB_SLAVE_PROTOCOL_CHECK_EN to gate writes on a clean setup/access pair and count violations.
module apb_slave_regfile
  import apb_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           NUM_REGS   = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                           PCLK,
  input  logic                           PRESETn,
  input  logic [ADDR_WIDTH-1:0]          PADDR,
  input  logic                           PSEL,
  input  logic                           PENABLE,
  input  logic                           PWRITE,
  input  logic [DATA_WIDTH-1:0]          PWDATA,
  output logic [DATA_WIDTH-1:0]          PRDATA,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
  output logic [ERR_COUNT_W-1:0]         err_count
);

  localparam int unsigned           IdxW        = $clog2(NUM_REGS);
  localparam logic [ADDR_WIDTH-1:0] WindowBytes = ADDR_WIDTH'(NUM_REGS) << APB_WORD_SHIFT;

  logic [ADDR_WIDTH-1:0] offset;
  logic                  in_range;
  logic [IdxW-1:0]       idx;
  logic                  setup_entry;
  logic                  wr_en;

  // Unsigned subtraction folds both window bounds into a single compare.
  assign offset   = PADDR - BASE_ADDR;
  assign in_range = offset < WindowBytes;
  assign idx      = offset[IdxW+APB_WORD_SHIFT-1:APB_WORD_SHIFT];

`ifdef APB_SLAVE_PROTOCOL_CHECK_EN
  logic access_ok;

  apb_protocol_checker #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_checker (
    .clk_i        (PCLK),
    .rst_ni       (PRESETn),
    .psel_i       (PSEL),
    .penable_i    (PENABLE),
    .pwrite_i     (PWRITE),
    .paddr_i      (PADDR),
    .setup_entry_o(setup_entry),
    .access_ok_o  (access_ok),
    .err_count_o  (err_count)
  );

  // PADDR matches the captured setup address here, so the live decode is the captured one.
  assign wr_en = access_ok & PWRITE & in_range;
`else
  apb_state_e state_q, state_d;

  always_comb begin
    state_d = apb_next_state(state_q, PSEL, PENABLE);
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  assign setup_entry = PSEL & ~PENABLE & (state_q != StSetup);
  assign wr_en       = PSEL & PENABLE & PWRITE & in_range;
  assign err_count   = '0;
`endif

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic [DATA_WIDTH-1:0] prdata_q, prdata_d;

  always_comb begin
    regs_d = regs_q;
    if (wr_en) regs_d[idx] = PWDATA;
  end

  // Read through the next-state array so a write landing on the same edge is forwarded.
  always_comb begin
    prdata_d = '0;
    if (setup_entry && !PWRITE && in_range) prdata_d = regs_d[idx];
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      prdata_q <= '0;
    end else begin
      regs_q   <= regs_d;
      prdata_q <= prdata_d;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
    assign regs_o[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
  end

  assign PRDATA = prdata_q;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Scoreboard bench for apb_slave_regfile; honours APB_SLAVE_PROTOCOL_CHECK_EN when defined.
module tb_apb_slave_regfile;

  localparam int unsigned NR   = 16;
  localparam logic [31:0] BASE = 32'h0000_0100;

  logic           PCLK = 1'b0;
  logic           PRESETn;
  logic [31:0]    PADDR;
  logic           PSEL;
  logic           PENABLE;
  logic           PWRITE;
  logic [31:0]    PWDATA;
  logic [31:0]    PRDATA;
  logic [NR*32-1:0] regs_o;
  logic [7:0]     err_count;

  apb_slave_regfile #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .NUM_REGS  (NR),
    .BASE_ADDR (BASE)
  ) dut (
    .PCLK     (PCLK),
    .PRESETn  (PRESETn),
    .PADDR    (PADDR),
    .PSEL     (PSEL),
    .PENABLE  (PENABLE),
    .PWRITE   (PWRITE),
    .PWDATA   (PWDATA),
    .PRDATA   (PRDATA),
    .regs_o   (regs_o),
    .err_count(err_count)
  );

  always #5 PCLK = ~PCLK;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] model [NR];
  int unsigned model_err = 0;
  logic [31:0] exp_q [$];

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  function automatic bit in_win(input logic [31:0] a);
    logic [31:0] lim;
    lim = BASE + NR * 4;
    return (a >= BASE) && (a < lim);
  endfunction

  function automatic int unsigned widx(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return int'(off[5:2]);
  endfunction

  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < NR; i++) model[i] = '0;
    model_err = 0;
  endtask

  // One two-cycle transfer; leaves the bus in the access state so a caller may chain another.
  task automatic xfer(input bit wr, input logic [31:0] addr, input logic [31:0] data);
    PSEL    = 1'b1;
    PENABLE = 1'b0;
    PWRITE  = wr;
    PADDR   = addr;
    PWDATA  = wr ? data : $urandom;
    if (!wr) exp_q.push_back(in_win(addr) ? model[widx(addr)] : 32'h0);
    step();
    PENABLE = 1'b1;
    step();
    if (wr && in_win(addr)) model[widx(addr)] = data;
  endtask

  task automatic idle();
    PSEL    = 1'b0;
    PENABLE = 1'b0;
    PWRITE  = 1'($urandom);
    PADDR   = $urandom;
    step();
  endtask

  // Monitor: register image and error count every cycle, PRDATA against the scoreboard.
  always @(negedge PCLK) begin
    logic [511:0] exp_flat;
    exp_flat = '0;
    for (int i = 0; i < NR; i++) exp_flat[i*32 +: 32] = model[i];
    check("regs_o", 512'(regs_o), exp_flat);
    check("err_count", 512'(err_count), 512'(model_err));
    if (PRESETn === 1'b1 && PSEL && PENABLE && !PWRITE) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL prdata_unexpected: got %0h want no read pending", PRDATA);
      end else begin
        check("prdata_read", 512'(PRDATA), 512'(exp_q.pop_front()));
      end
    end else begin
      check("prdata_idle", 512'(PRDATA), 512'(0));
    end
  end

  initial begin
    logic [31:0] a;
    PRESETn = 1'b0;
    PSEL    = 1'b0;
    PENABLE = 1'b0;
    PWRITE  = 1'b0;
    PADDR   = '0;
    PWDATA  = '0;
    clear_model();
    repeat (3) step();
    PRESETn = 1'b1;
    step();
    check("reset_regs", 512'(regs_o), 512'(0));
    check("reset_prdata", 512'(PRDATA), 512'(0));
    check("reset_err", 512'(err_count), 512'(0));

    xfer(1'b1, BASE + 32'h8, 32'hDEAD_BEEF);
    idle();
    xfer(1'b0, BASE + 32'h8, 32'h0);
    idle();
    check("reg2_deadbeef", 512'(regs_o[2*32 +: 32]), 512'(32'hDEAD_BEEF));

    xfer(1'b1, BASE + 32'h4, 32'h1);
    xfer(1'b0, BASE + 32'h4, 32'h0);
    idle();

    xfer(1'b1, BASE + 32'h40, 32'h55);
    idle();
    xfer(1'b0, BASE + 32'h40, 32'h0);
    idle();

    // Access phase straight out of idle.
    PSEL    = 1'b1;
    PENABLE = 1'b1;
    PWRITE  = 1'b1;
    PADDR   = BASE;
    PWDATA  = 32'h77;
    step();
`ifdef APB_SLAVE_PROTOCOL_CHECK_EN
    model_err = model_err + 1;
`else
    model[0] = 32'h77;
`endif
    idle();
`ifdef APB_SLAVE_PROTOCOL_CHECK_EN
    check("nosetup_reg0", 512'(regs_o[31:0]), 512'(0));
    check("nosetup_err", 512'(err_count), 512'(1));
`else
    check("nosetup_reg0", 512'(regs_o[31:0]), 512'(32'h77));
`endif

    for (int n = 0; n < 200; n++) begin
      int unsigned r;
      r = $urandom_range(0, 9);
      if (r < 8)       a = BASE + ($urandom_range(0, NR - 1) << 2) + $urandom_range(0, 3);
      else if (r == 8) a = BASE + NR * 4 + $urandom_range(0, 255);
      else             a = BASE - 1 - $urandom_range(0, 255);
      xfer(1'($urandom_range(0, 1)), a, $urandom);
      if ($urandom_range(0, 2) == 0) idle();
    end
    idle();
    idle();

    // Reset in the middle of a write access.
    PSEL    = 1'b1;
    PENABLE = 1'b0;
    PWRITE  = 1'b1;
    PADDR   = BASE + 32'hC;
    PWDATA  = 32'h0000_AAAA;
    step();
    PENABLE = 1'b1;
    #2;
    PRESETn = 1'b0;
    clear_model();
    #1;
    check("midreset_regs", 512'(regs_o), 512'(0));
    check("midreset_prdata", 512'(PRDATA), 512'(0));
    check("midreset_err", 512'(err_count), 512'(0));
    step();
    PSEL    = 1'b0;
    PENABLE = 1'b0;
    step();
    PRESETn = 1'b1;
    step();
    check("midreset_reg3", 512'(regs_o[3*32 +: 32]), 512'(0));
    xfer(1'b0, BASE + 32'hC, 32'h0);
    idle();
    idle();

    check("scoreboard_drain", 512'(exp_q.size()), 512'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
